// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared types and constants for the AES round sequencer.
// State encoding, datapath mux selects and job direction codes.
package aes_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KEYEXP,
    ARK,
    ROUND,
    FINAL,
    DONE
  } seqState_t;

  localparam logic [1:0] CTRL_ROUND = 2'b00;
  localparam logic [1:0] CTRL_FINAL = 2'b01;
  localparam logic [1:0] CTRL_LOAD  = 2'b10;
  localparam logic [1:0] CTRL_ARK   = 2'b11;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/aes_round_seq_if.sv
// aes_round_seq_if: job request / result valid-ready handshake bundle.
// master drives jobs and consumes results; slave is the sequencer.
interface aes_round_seq_if;

  logic in_valid;
  logic in_ready;
  logic in_mode;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid
  );

endinterface

// File: rtl/aes_round_cnt.sv
// aes_round_cnt: loadable up/down round counter.
// match flags equality with the supplied terminal value.
module aes_round_cnt #(
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ITER_W-1:0] loadVal,
  input  logic              en,
  input  logic              up,
  input  logic [ITER_W-1:0] cmpVal,
  output logic [ITER_W-1:0] cnt,
  output logic              match
);

  // load wins over counting so every state entry starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (en) begin
      cnt <= up ? cnt + ITER_W'(1) : cnt - ITER_W'(1);
    end
  end

  assign match = (cnt == cmpVal);

endmodule

// File: rtl/aes_round_seq.sv
// aes_round_seq: sequencer for the shared iterative AES round datapath.
// Optional AES_SEQ_ABORT_EN adds an abort input that returns to IDLE.
import aes_seq_pkg::*;

module aes_round_seq #(
  parameter int NR     = 10,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_round_seq_if.slave    hs,
`ifdef AES_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [1:0]        ctrl,
  output logic [ITER_W-1:0] iterate,
  output logic              state_en,
  output logic              key_en,
  output logic              out_capture,
  output logic              busy
);

  localparam logic [ITER_W-1:0] ZERO  = '0;
  localparam logic [ITER_W-1:0] ONE   = ITER_W'(1);
  localparam logic [ITER_W-1:0] NR_I  = ITER_W'(NR);
  localparam logic [ITER_W-1:0] NR_M1 = ITER_W'(NR - 1);

  seqState_t         state;
  seqState_t         stateNxt;
  logic              mode;
  logic              load;
  logic [ITER_W-1:0] loadVal;
  logic [ITER_W-1:0] cmpVal;
  logic              cntEn;
  logic              cntUp;
  logic [ITER_W-1:0] cnt;
  logic              match;
  logic              abortHit;
  logic              isEnc;

`ifdef AES_SEQ_ABORT_EN
  assign abortHit = abort && (state != IDLE);
`else
  assign abortHit = 1'b0;
`endif

  assign isEnc = (mode == MODE_ENC);

  aes_round_cnt #(.ITER_W(ITER_W)) uCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .loadVal (loadVal),
    .en      (cntEn),
    .up      (cntUp),
    .cmpVal  (cmpVal),
    .cnt     (cnt),
    .match   (match)
  );

  // state register; direction is frozen at job accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode  <= MODE_ENC;
    end else begin
      state <= stateNxt;
      if (state == IDLE && hs.in_valid) begin
        mode <= hs.in_mode;
      end
    end
  end

  // next state plus counter reload value for the state being entered
  always_comb begin
    stateNxt = state;
    load     = 1'b0;
    loadVal  = ZERO;
    cntEn    = 1'b0;
    cntUp    = 1'b1;
    cmpVal   = ZERO;
    unique case (1'b1)
      (state == IDLE): begin
        if (hs.in_valid) begin
          stateNxt = LOAD;
          load     = 1'b1;
        end
      end
      (state == LOAD): begin
        load = 1'b1;
        if (isEnc) begin
          stateNxt = ARK;
        end else begin
          stateNxt = KEYEXP;
          loadVal  = ONE;
        end
      end
      (state == KEYEXP): begin
        cmpVal = NR_I;
        if (match) begin
          stateNxt = ARK;
          load     = 1'b1;
          loadVal  = NR_I;
        end else begin
          cntEn = 1'b1;
        end
      end
      (state == ARK): begin
        stateNxt = ROUND;
        load     = 1'b1;
        loadVal  = isEnc ? ONE : NR_M1;
      end
      (state == ROUND): begin
        cntUp  = isEnc;
        cmpVal = isEnc ? NR_M1 : ONE;
        if (match) begin
          stateNxt = FINAL;
          load     = 1'b1;
          loadVal  = isEnc ? NR_I : ZERO;
        end else begin
          cntEn = 1'b1;
        end
      end
      (state == FINAL): begin
        stateNxt = DONE;
        load     = 1'b1;
      end
      (state == DONE): begin
        if (hs.out_ready) begin
          stateNxt = IDLE;
        end
      end
      default: begin
        stateNxt = IDLE;
        load     = 1'b1;
      end
    endcase
    if (abortHit) begin
      stateNxt = IDLE;
      load     = 1'b1;
      loadVal  = ZERO;
      cntEn    = 1'b0;
    end
  end

  // Moore decode of datapath controls
  always_comb begin
    ctrl        = CTRL_ROUND;
    state_en    = 1'b0;
    key_en      = 1'b0;
    out_capture = 1'b0;
    unique case (1'b1)
      (state == LOAD): begin
        ctrl     = CTRL_LOAD;
        state_en = 1'b1;
        key_en   = 1'b1;
      end
      (state == KEYEXP): begin
        key_en = 1'b1;
      end
      (state == ARK): begin
        ctrl     = CTRL_ARK;
        state_en = 1'b1;
        key_en   = 1'b1;
      end
      (state == ROUND): begin
        state_en = 1'b1;
        key_en   = 1'b1;
      end
      (state == FINAL): begin
        ctrl        = CTRL_FINAL;
        state_en    = 1'b1;
        key_en      = 1'b1;
        out_capture = 1'b1;
      end
      default: begin
        ctrl = CTRL_ROUND;
      end
    endcase
  end

  assign iterate      = cnt;
  assign busy         = (state != IDLE);
  assign hs.in_ready  = (state == IDLE);
  assign hs.out_valid = (state == DONE);

endmodule

// File: tb/tb_aes_round_seq.sv
// tb_aes_round_seq: randomized self-checking bench for aes_round_seq.
// Expected control streams come from a per-phase job model.
module tb_aes_round_seq;

  localparam int NR     = 10;
  localparam int ITER_W = 8;

  typedef struct packed {
    logic [1:0]        c;
    logic [ITER_W-1:0] it;
    logic              s;
    logic              k;
    logic              cap;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_round_seq_if hs();

  logic [1:0]        ctrl;
  logic [ITER_W-1:0] iterate;
  logic              state_en;
  logic              key_en;
  logic              out_capture;
  logic              busy;
`ifdef AES_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  aes_round_seq #(.NR(NR), .ITER_W(ITER_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hs          (hs.slave),
`ifdef AES_SEQ_ABORT_EN
    .abort       (abort),
`endif
    .ctrl        (ctrl),
    .iterate     (iterate),
    .state_en    (state_en),
    .key_en      (key_en),
    .out_capture (out_capture),
    .busy        (busy)
  );

  int compared = 0;
  int mismatched = 0;
  int edges = 0;
  step_t expQ[$];

  localparam logic [15:0] IDLE_W = {2'b00, 8'h00, 3'b000, 3'b010};
  localparam logic [15:0] DONE_W = {2'b00, 8'h00, 3'b000, 3'b101};

  always @(posedge clk) edges++;

  function automatic logic [15:0] obs();
    return {ctrl, iterate, state_en, key_en, out_capture,
            busy, hs.in_ready, hs.out_valid};
  endfunction

  function automatic step_t mk(input logic [1:0] c, input int it,
                               input logic s, input logic k,
                               input logic cap);
    step_t r;
    r.c = c;
    r.it = ITER_W'(it);
    r.s = s;
    r.k = k;
    r.cap = cap;
    return r;
  endfunction

  // job model: phase list per direction, one entry per busy cycle
  task automatic buildExp(input logic m);
    expQ.delete();
    expQ.push_back(mk(2'b10, 0, 1, 1, 0));
    if (m) begin
      for (int i = 1; i <= NR; i++) expQ.push_back(mk(2'b00, i, 0, 1, 0));
      expQ.push_back(mk(2'b11, NR, 1, 1, 0));
      for (int i = NR - 1; i >= 1; i--) expQ.push_back(mk(2'b00, i, 1, 1, 0));
      expQ.push_back(mk(2'b01, 0, 1, 1, 1));
    end else begin
      expQ.push_back(mk(2'b11, 0, 1, 1, 0));
      for (int i = 1; i <= NR - 1; i++) expQ.push_back(mk(2'b00, i, 1, 1, 0));
      expQ.push_back(mk(2'b01, NR, 1, 1, 1));
    end
  endtask

  // cutKind: 0 none, 1 async reset, 2 abort; applied after step cutAt
  task automatic runJob(input logic m, input bit perturb, input int bp,
                        input int cutAt, input int cutKind,
                        input string tag);
    int startEdge;
    int lat;
    int expLat;
    logic [15:0] want;
    @(negedge clk);
    compared++;
    if (obs() !== IDLE_W) begin
      mismatched++;
      $display("FAIL %s pre-idle: got %h want %h", tag, obs(), IDLE_W);
    end
    hs.in_valid = 1'b1;
    hs.in_mode = m;
    hs.out_ready = 1'b0;
    buildExp(m);
    startEdge = edges;
    for (int i = 0; i < expQ.size(); i++) begin
      @(negedge clk);
      want = {expQ[i], 3'b100};
      compared++;
      if (obs() !== want) begin
        mismatched++;
        $display("FAIL %s step %0d: got %h want %h", tag, i, obs(), want);
      end
      if (perturb) begin
        hs.in_valid = 1'($urandom);
        hs.in_mode = 1'($urandom);
        hs.out_ready = 1'($urandom);
      end else begin
        hs.in_valid = 1'b0;
      end
      if (i == cutAt && cutKind == 1) begin
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (obs() !== IDLE_W) begin
          mismatched++;
          $display("FAIL %s async-reset: got %h want %h", tag, obs(), IDLE_W);
        end
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
`ifdef AES_SEQ_ABORT_EN
      if (i == cutAt && cutKind == 2) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int j = 0; j < 4; j++) begin
          compared++;
          if (obs() !== IDLE_W) begin
            mismatched++;
            $display("FAIL %s abort-idle %0d: got %h want %h",
                     tag, j, obs(), IDLE_W);
          end
          @(negedge clk);
        end
        return;
      end
`endif
    end
    @(negedge clk);
    lat = edges - startEdge;
    expLat = m ? 2 * NR + 3 : NR + 3;
    compared++;
    if (lat !== expLat) begin
      mismatched++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, expLat);
    end
    compared++;
    if (obs() !== DONE_W) begin
      mismatched++;
      $display("FAIL %s done: got %h want %h", tag, obs(), DONE_W);
    end
    for (int j = 0; j < bp; j++) begin
      hs.out_ready = 1'b0;
      hs.in_valid = perturb ? 1'($urandom) : 1'b0;
      @(negedge clk);
      compared++;
      if (obs() !== DONE_W) begin
        mismatched++;
        $display("FAIL %s hold %0d: got %h want %h", tag, j, obs(), DONE_W);
      end
    end
    hs.out_ready = 1'b1;
    hs.in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (obs() !== IDLE_W) begin
      mismatched++;
      $display("FAIL %s release: got %h want %h", tag, obs(), IDLE_W);
    end
    for (int j = 0; j < 2; j++) begin
      hs.out_ready = 1'($urandom);
      @(negedge clk);
      compared++;
      if (obs() !== IDLE_W) begin
        mismatched++;
        $display("FAIL %s stray %0d: got %h want %h", tag, j, obs(), IDLE_W);
      end
    end
    hs.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    hs.in_valid = 1'b0;
    hs.in_mode = 1'b0;
    hs.out_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    compared++;
    if (obs() !== IDLE_W) begin
      mismatched++;
      $display("FAIL reset: got %h want %h", obs(), IDLE_W);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (obs() !== IDLE_W) begin
      mismatched++;
      $display("FAIL post-reset: got %h want %h", obs(), IDLE_W);
    end
  endtask

  task automatic test_encrypt();
    runJob(1'b0, 1'b0, 0, -1, 0, "enc");
  endtask

  task automatic test_decrypt();
    runJob(1'b1, 1'b0, 0, -1, 0, "dec");
  endtask

  task automatic test_backpressure();
    runJob(1'b0, 1'b0, 5, -1, 0, "bp");
  endtask

  task automatic test_ignored_inputs();
    runJob(1'b0, 1'b1, 2, -1, 0, "ign-enc");
    runJob(1'b1, 1'b1, 1, -1, 0, "ign-dec");
  endtask

  task automatic test_reset_mid();
    runJob(1'b0, 1'b0, 0, 5, 1, "rst-mid");
    runJob(1'b0, 1'b0, 0, -1, 0, "after-rst");
  endtask

  task automatic test_abort();
`ifdef AES_SEQ_ABORT_EN
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    compared++;
    if (obs() !== IDLE_W) begin
      mismatched++;
      $display("FAIL abort-in-idle: got %h want %h", obs(), IDLE_W);
    end
    runJob(1'b1, 1'b0, 0, 3, 2, "abort");
    runJob(1'b1, 1'b0, 0, -1, 0, "after-abort");
`endif
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      runJob(1'($urandom), 1'($urandom), int'($urandom_range(0, 5)),
             -1, 0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_ignored_inputs();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
